// File: rtl/sensor_poll_seq.sv
// Round-robin poller for three SPI sensors: 2-cycle request per slave, byte captured on ss release and visible one cycle after CAPTURE.
// No backpressure beyond the slave-select handshake; a stalled slave is abandoned after TIMEOUT cycles.
module sensor_poll_seq #(
  parameter int         POLL_GAP = 16,
  parameter int         TIMEOUT  = 64,
  parameter logic [7:0] ADDR1    = 8'h03,
  parameter logic [7:0] ADDR2    = 8'h02,
  parameter logic [7:0] ADDR3    = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] mask,
  input  logic       ss1,
  input  logic       ss2,
  input  logic       ss3,
  input  logic [7:0] sensor,
  output logic       sendOrder,
  output logic [1:0] ssi,
  output logic [7:0] address,
  output logic [7:0] result1,
  output logic [7:0] result2,
  output logic [7:0] result3,
  output logic [2:0] valid,
  output logic       upd,
  output logic [1:0] upd_idx,
  output logic       timeout_err
);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);
  localparam logic [GCW-1:0] G_LAST = GCW'(POLL_GAP - 1);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_START, WAIT_END, CAPTURE, GAP} state_t;

  state_t         state, state_nx;
  logic [1:0]     sel, last, pick;
  logic [1:0]     c1, c2, c3;
  logic [TCW-1:0] tcnt;
  logic [GCW-1:0] gcnt;
  logic           ss_cur, tmo_hit, tmo_end;

  function automatic logic [7:0] addr_of(input logic [1:0] idx);
    case (idx)
      2'd1:    return ADDR1;
      2'd2:    return ADDR2;
      2'd3:    return ADDR3;
      default: return 8'h00;
    endcase
  endfunction

  // search order starts just after the last-served slave and wraps 3 -> 1
  always_comb begin
    case (last)
      2'd1:    {c1, c2, c3} = {2'd2, 2'd3, 2'd1};
      2'd2:    {c1, c2, c3} = {2'd3, 2'd1, 2'd2};
      default: {c1, c2, c3} = {2'd1, 2'd2, 2'd3};
    endcase
    if (mask[c1 - 2'd1])      pick = c1;
    else if (mask[c2 - 2'd1]) pick = c2;
    else if (mask[c3 - 2'd1]) pick = c3;
    else                      pick = 2'd0;
  end

  always_comb begin
    case (sel)
      2'd1:    ss_cur = ss1;
      2'd2:    ss_cur = ss2;
      default: ss_cur = ss3;
    endcase
  end

  assign tmo_hit = (tcnt == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sendOrder = 1'b0;
    ssi       = 2'd0;
    address   = 8'h00;
    upd       = 1'b0;
    upd_idx   = 2'd0;
    tmo_end   = 1'b0;
    case (state)
      IDLE: if (enable && mask != 3'b000) state_nx = SELECT;
      SELECT: begin
        ssi      = pick;
        address  = addr_of(pick);
        state_nx = (pick != 2'd0) ? ISSUE : IDLE;
      end
      ISSUE: begin
        sendOrder = 1'b1;
        ssi       = sel;
        address   = addr_of(sel);
        if (tmo_hit) begin
          state_nx = GAP;
          tmo_end  = 1'b1;
        end else if (tcnt == TCW'(1)) begin
          state_nx = WAIT_START;
        end
      end
      WAIT_START: begin
        ssi     = sel;
        address = addr_of(sel);
        if (tmo_hit) begin
          state_nx = GAP;
          tmo_end  = 1'b1;
        end else if (!ss_cur) begin
          state_nx = WAIT_END;
        end
      end
      WAIT_END: begin
        ssi     = sel;
        address = addr_of(sel);
        // a release on the final allowed cycle still counts as a completed read
        if (ss_cur) begin
          state_nx = CAPTURE;
        end else if (tmo_hit) begin
          state_nx = GAP;
          tmo_end  = 1'b1;
        end
      end
      CAPTURE: begin
        ssi      = sel;
        address  = addr_of(sel);
        upd      = 1'b1;
        upd_idx  = sel;
        state_nx = GAP;
      end
      GAP: if (gcnt == G_LAST) state_nx = (enable && mask != 3'b000) ? SELECT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= 2'd0;
      last        <= 2'd3;
      tcnt        <= '0;
      gcnt        <= '0;
      result1     <= 8'h00;
      result2     <= 8'h00;
      result3     <= 8'h00;
      valid       <= 3'b000;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_end;
      if (state == SELECT) sel <= pick;
      tcnt <= (state inside {ISSUE, WAIT_START, WAIT_END}) ? tcnt + TCW'(1) : '0;
      gcnt <= (state == GAP) ? gcnt + GCW'(1) : '0;
      if (state == CAPTURE || tmo_end) last <= sel;
      if (state == CAPTURE) begin
        case (sel)
          2'd1: begin result1 <= sensor; valid[0] <= 1'b1; end
          2'd2: begin result2 <= sensor; valid[1] <= 1'b1; end
          2'd3: begin result3 <= sensor; valid[2] <= 1'b1; end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sensor_poll_seq.sv
// Randomized bench for sensor_poll_seq: SPI master/slave model drives ss/sensor, event logs are checked against round-robin expectations.
module tb_sensor_poll_seq;
  localparam int POLL_GAP = 16;
  localparam int TIMEOUT  = 64;

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [2:0] mask = 3'b000;
  logic       ss1, ss2, ss3;
  logic [7:0] sensor = 8'h00;
  logic       sendOrder, upd, timeout_err;
  logic [1:0] ssi, upd_idx;
  logic [7:0] address, result1, result2, result3;
  logic [2:0] valid;

  sensor_poll_seq #(.POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT),
                    .ADDR1(8'h03), .ADDR2(8'h02), .ADDR3(8'h08)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mask(mask),
    .ss1(ss1), .ss2(ss2), .ss3(ss3), .sensor(sensor),
    .sendOrder(sendOrder), .ssi(ssi), .address(address),
    .result1(result1), .result2(result2), .result3(result3),
    .valid(valid), .upd(upd), .upd_idx(upd_idx), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  logic ss_drv [1:3];
  assign ss1 = ss_drv[1];
  assign ss2 = ss_drv[2];
  assign ss3 = ss_drv[3];

  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] resp [1:3];
  bit         mute [1:3];
  bit         noise = 1'b1;
  int m_phase, m_dly, m_low, m_idx;
  int dly_min, dly_max, low_min, low_max;

  int         so_cyc[$], so_len[$], so_zr[$], cap_cyc[$], to_cyc[$];
  logic [1:0] so_ssi[$], cap_idx[$];
  logic [7:0] so_addr[$], cap_res[$];
  bit         prev_so, prev_upd;
  logic [1:0] prev_idx;
  int         so_cnt, zrun, last_zr;

  function automatic logic [7:0] exp_addr(input int i);
    case (i)
      1: return 8'h03;
      2: return 8'h02;
      3: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] res_of(input logic [1:0] i);
    case (i)
      2'd1: return result1;
      2'd2: return result2;
      default: return result3;
    endcase
  endfunction

  task automatic clear_logs();
    so_cyc.delete(); so_len.delete(); so_zr.delete(); cap_cyc.delete(); to_cyc.delete();
    so_ssi.delete(); cap_idx.delete(); so_addr.delete(); cap_res.delete();
    prev_so = 0; prev_upd = 0; prev_idx = 2'd0; so_cnt = 0; zrun = 0; last_zr = 0;
  endtask

  // one cycle: log DUT outputs at the falling edge, then advance the slave model
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ssi != 2'd0 && zrun > 0) last_zr = zrun;
    zrun = (ssi == 2'd0) ? zrun + 1 : 0;
    if (sendOrder && !prev_so) begin
      so_cyc.push_back(cyc); so_ssi.push_back(ssi); so_addr.push_back(address);
      so_zr.push_back(last_zr); so_cnt = 0;
    end
    if (sendOrder) so_cnt++;
    else if (prev_so) so_len.push_back(so_cnt);
    if (prev_upd) cap_res.push_back(res_of(prev_idx));
    if (upd) begin cap_idx.push_back(upd_idx); cap_cyc.push_back(cyc); end
    if (timeout_err) to_cyc.push_back(cyc);
    prev_so = sendOrder; prev_upd = upd; prev_idx = upd_idx;

    if (m_phase == 0) begin
      if (sendOrder && ssi != 2'd0 && !mute[ssi]) begin
        m_phase = 1; m_idx = int'(ssi);
        m_dly = $urandom_range(dly_max, dly_min);
        m_low = $urandom_range(low_max, low_min);
      end
    end else if (m_phase == 1) begin
      if (m_dly == 0) begin m_phase = 2; sensor = resp[m_idx]; end
      else m_dly--;
    end else begin
      m_low--;
      if (m_low == 0) m_phase = 0;
    end
    for (int i = 1; i <= 3; i++) begin
      if (m_phase == 2 && i == m_idx) ss_drv[i] = 1'b0;
      else if (i == int'(ssi))        ss_drv[i] = 1'b1;
      else                            ss_drv[i] = noise ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; m_phase = 0;
    dly_min = 0; dly_max = 3; low_min = 1; low_max = 5;
    for (int i = 1; i <= 3; i++) begin ss_drv[i] = 1'b1; mute[i] = 1'b0; end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic run_events(input int n, input int budget, output bit ok);
    int k = 0;
    while (cap_idx.size() + to_cyc.size() < n && k < budget) begin tick(); k++; end
    ok = (cap_idx.size() + to_cyc.size() >= n);
    repeat (2) tick();
  endtask

  task automatic test_reset();
    logic [41:0] v;
    enable = 1'b1; mask = 3'b111;
    repeat (3) @(negedge clk);
    v = {sendOrder, ssi, address, result1, result2, result3, valid, upd, upd_idx, timeout_err};
    tests++; if (v !== '0) begin fails++; $display("FAIL reset_outputs: got %h expected 0", v); end
    do_reset();
    mask = 3'b111;
    repeat (20) tick();
    tests++; if (so_cyc.size() != 0) begin fails++; $display("FAIL idle_no_order: got %0d requests expected 0", so_cyc.size()); end
    tests++; if (ssi !== 2'b00) begin fails++; $display("FAIL idle_ssi: got %b expected 00", ssi); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    resp[1] = 8'h4c; mask = 3'b001; enable = 1'b1;
    run_events(1, 300, ok);
    enable = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL single_capture: got no capture expected one"); end
    tests++; if (so_ssi[0] !== 2'b01) begin fails++; $display("FAIL single_ssi: got %b expected 01", so_ssi[0]); end
    tests++; if (so_addr[0] !== 8'h03) begin fails++; $display("FAIL single_addr: got %h expected 03", so_addr[0]); end
    tests++; if (so_len[0] != 2) begin fails++; $display("FAIL single_order_len: got %0d expected 2", so_len[0]); end
    tests++; if (cap_idx[0] !== 2'b01) begin fails++; $display("FAIL single_upd_idx: got %b expected 01", cap_idx[0]); end
    tests++; if (cap_res[0] !== 8'h4c) begin fails++; $display("FAIL single_result1: got %h expected 4c", cap_res[0]); end
    tests++; if (valid !== 3'b001) begin fails++; $display("FAIL single_valid: got %b expected 001", valid); end
  endtask

  // expected service order after reset: enabled slaves ascending, repeated cyclically
  task automatic test_order(input logic [2:0] m, input int n, input bit is_rand);
    bit ok;
    int en[$];
    int k;
    logic [2:0] exp_valid;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      resp[i] = 8'($urandom);
      if (m[i-1]) en.push_back(i);
      if (is_rand) mute[i] = ($urandom_range(3, 0) == 0);
    end
    mask = m; enable = 1'b1;
    run_events(n, 400 * n, ok);
    enable = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL order_events m=%b: got %0d expected %0d", m, cap_idx.size() + to_cyc.size(), n); end
    k = 0; exp_valid = 3'b000;
    for (int j = 0; j < n; j++) begin
      int s = en[j % en.size()];
      tests++; if (so_ssi[j] !== 2'(s)) begin fails++; $display("FAIL order_ssi m=%b #%0d: got %b expected %0d", m, j, so_ssi[j], s); end
      tests++; if (so_addr[j] !== exp_addr(s)) begin fails++; $display("FAIL order_addr m=%b #%0d: got %h expected %h", m, j, so_addr[j], exp_addr(s)); end
      tests++; if (so_len[j] != 2) begin fails++; $display("FAIL order_len m=%b #%0d: got %0d expected 2", m, j, so_len[j]); end
      if (j > 0) begin
        tests++; if (so_zr[j] != POLL_GAP) begin fails++; $display("FAIL order_gap m=%b #%0d: got %0d expected %0d", m, j, so_zr[j], POLL_GAP); end
      end
      if (!mute[s]) begin
        tests++; if (cap_idx[k] !== 2'(s)) begin fails++; $display("FAIL order_upd_idx m=%b #%0d: got %b expected %0d", m, j, cap_idx[k], s); end
        tests++; if (cap_res[k] !== resp[s]) begin fails++; $display("FAIL order_result m=%b #%0d: got %h expected %h", m, j, cap_res[k], resp[s]); end
        exp_valid[s-1] = 1'b1;
        k++;
      end
    end
    tests++; if (cap_idx.size() != k) begin fails++; $display("FAIL order_capture_count m=%b: got %0d expected %0d", m, cap_idx.size(), k); end
    tests++; if (valid !== exp_valid) begin fails++; $display("FAIL order_valid m=%b: got %b expected %b", m, valid, exp_valid); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    mute[2] = 1'b1; mask = 3'b010; enable = 1'b1;
    run_events(2, 600, ok);
    enable = 1'b0;
    tests++; if (!ok || to_cyc.size() != 2) begin fails++; $display("FAIL timeout_count: got %0d expected 2", to_cyc.size()); end
    tests++; if (to_cyc[0] - so_cyc[0] != TIMEOUT) begin fails++; $display("FAIL timeout_latency: got %0d expected %0d", to_cyc[0] - so_cyc[0], TIMEOUT); end
    tests++; if (cap_idx.size() != 0) begin fails++; $display("FAIL timeout_no_upd: got %0d expected 0", cap_idx.size()); end
    tests++; if ({valid, result2} !== 11'h0) begin fails++; $display("FAIL timeout_state: got valid=%b result2=%h expected 000/00", valid, result2); end
    tests++; if (so_ssi[1] !== 2'b10) begin fails++; $display("FAIL timeout_retry_ssi: got %b expected 10", so_ssi[1]); end
    tests++; if (so_zr[1] != POLL_GAP) begin fails++; $display("FAIL timeout_gap: got %0d expected %0d", so_zr[1], POLL_GAP); end
  endtask

  // ss released on the last allowed cycle must capture; one cycle later must time out
  task automatic test_timeout_race(input bit late);
    bit ok;
    do_reset();
    dly_min = 0; dly_max = 0;
    low_min = late ? TIMEOUT - 1 : TIMEOUT - 2; low_max = low_min;
    resp[1] = 8'h5a; mask = 3'b001; enable = 1'b1;
    run_events(1, 300, ok);
    enable = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL race_event late=%0d: got none expected one", late); end
    if (late) begin
      tests++; if (to_cyc.size() != 1 || cap_idx.size() != 0) begin fails++; $display("FAIL race_late late=1: got %0d timeouts %0d captures expected 1/0", to_cyc.size(), cap_idx.size()); end
      tests++; if (valid !== 3'b000) begin fails++; $display("FAIL race_late_valid: got %b expected 000", valid); end
    end else begin
      tests++; if (to_cyc.size() != 0 || cap_idx.size() != 1) begin fails++; $display("FAIL race_edge late=0: got %0d timeouts %0d captures expected 0/1", to_cyc.size(), cap_idx.size()); end
      tests++; if (cap_cyc[0] - so_cyc[0] != TIMEOUT) begin fails++; $display("FAIL race_edge_cycle: got %0d expected %0d", cap_cyc[0] - so_cyc[0], TIMEOUT); end
      tests++; if (cap_res[0] !== 8'h5a) begin fails++; $display("FAIL race_edge_result: got %h expected 5a", cap_res[0]); end
    end
  endtask

  task automatic test_enable_drop();
    int k = 0;
    do_reset();
    low_min = 6; low_max = 6;
    resp[1] = 8'h4c; resp[2] = 8'h88; resp[3] = 8'h77;
    mask = 3'b111; enable = 1'b1;
    while (m_phase != 2 && k < 300) begin tick(); k++; end
    tick();
    enable = 1'b0;
    repeat (3 * POLL_GAP + 20) tick();
    tests++; if (cap_idx.size() != 1) begin fails++; $display("FAIL drop_capture: got %0d expected 1", cap_idx.size()); end
    tests++; if (cap_res[0] !== 8'h4c) begin fails++; $display("FAIL drop_result: got %h expected 4c", cap_res[0]); end
    tests++; if (so_cyc.size() != 1) begin fails++; $display("FAIL drop_no_reissue: got %0d requests expected 1", so_cyc.size()); end
    tests++; if ({sendOrder, ssi} !== 3'b000) begin fails++; $display("FAIL drop_idle: got %b expected 000", {sendOrder, ssi}); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    logic [41:0] v;
    do_reset();
    low_min = 6; low_max = 6;
    resp[1] = 8'h4c; mask = 3'b001; enable = 1'b1;
    run_events(1, 300, ok);
    while (m_phase != 2 && k < 300) begin tick(); k++; end
    tick();
    tests++; if ({ssi, result1} !== 10'h14c) begin fails++; $display("FAIL midreset_pre: got ssi=%b result1=%h expected 01/4c", ssi, result1); end
    #1 reset = 1'b1;
    #1 v = {sendOrder, ssi, address, result1, result2, result3, valid, upd, upd_idx, timeout_err};
    tests++; if (v !== '0) begin fails++; $display("FAIL midreset_outputs: got %h expected 0", v); end
    m_phase = 0;
    clear_logs();
    repeat (3) tick();
    tests++; if (cap_idx.size() != 0 || valid !== 3'b000) begin fails++; $display("FAIL midreset_no_upd: got %0d captures valid=%b expected 0/000", cap_idx.size(), valid); end
    reset = 1'b0; enable = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    for (int i = 1; i <= 3; i++) begin ss_drv[i] = 1'b1; mute[i] = 1'b0; resp[i] = 8'h00; end
    m_phase = 0; dly_min = 0; dly_max = 3; low_min = 1; low_max = 5;
    clear_logs();
    test_reset();
    test_single();
    test_order(3'b111, 5, 1'b0);
    test_order(3'b101, 3, 1'b0);
    test_timeout();
    test_timeout_race(1'b0);
    test_timeout_race(1'b1);
    test_enable_drop();
    test_reset_mid();
    for (int it = 0; it < 4; it++) test_order(3'($urandom_range(7, 1)), 6, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sensor_poll_seq.md
SENSOR_POLL_SEQ -- requirements
Module: sensor_poll_seq

Interface
REQ-001 SHALL have parameter POLL_GAP, default 16, idle cycles between transactions (min 1).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles from ISSUE entry to transaction end.
REQ-003 SHALL have parameters ADDR1, ADDR2, ADDR3, defaults 8'h03, 8'h02, 8'h08, register address sent to slaves 1/2/3.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 enable  input  1  level; 1 = run polling loop.
REQ-007 mask  input  3  bit i-1 = 1 polls slave i.
REQ-008 ss1, ss2, ss3  input  1 each  slave selects from SPI master, active-low.
REQ-009 sensor  input  8  byte received by SPI master.
REQ-010 sendOrder  output  1  transaction request to SPI master.
REQ-011 ssi  output  2  slave index to master: 01/10/11 = slave 1/2/3, 00 = none.
REQ-012 address  output  8  address byte to master.
REQ-013 result1, result2, result3  output  8 each  last captured byte per slave.
REQ-014 valid  output  3  bit i-1 set once result i captured.
REQ-015 upd  output  1  one-cycle pulse on each capture.
REQ-016 upd_idx  output  2  slave index of the capture flagged by upd.
REQ-017 timeout_err  output  1  one-cycle pulse on timeout.

Function
REQ-018 FSM states SHALL be IDLE, SELECT, ISSUE, WAIT_START, WAIT_END, CAPTURE, GAP.
REQ-019 IDLE -> SELECT when enable=1 and mask!=0; otherwise stay IDLE.
REQ-020 SELECT (1 cycle) SHALL pick next slave round-robin after last-served index (order 1->2->3->1), skipping masked-off slaves; after reset, search starts at slave 1.
REQ-021 ISSUE SHALL last exactly 2 cycles with sendOrder=1, ssi=selected index, address=ADDRn; then -> WAIT_START.
REQ-022 ssi and address SHALL hold selected values from SELECT through CAPTURE; 00 and 8'h00 in IDLE and GAP.
REQ-023 WAIT_START -> WAIT_END on first cycle selected ss is 0.
REQ-024 WAIT_END -> CAPTURE on first cycle selected ss is 1.
REQ-025 CAPTURE (1 cycle) SHALL load sensor into resultn, set valid bit, pulse upd with upd_idx=n; result visible the cycle after CAPTURE.
REQ-026 GAP SHALL count POLL_GAP cycles, then -> SELECT if enable=1 and mask!=0, else IDLE.
REQ-027 Timeout counter SHALL start at 0 on ISSUE entry, increment each cycle in ISSUE/WAIT_START/WAIT_END; on reaching TIMEOUT -> GAP with timeout_err pulse, no capture, result/valid unchanged.
REQ-028 Ss of non-selected slaves SHALL be ignored.
REQ-029 enable deasserted mid-transaction SHALL NOT abort it; capture completes, then GAP -> IDLE.
REQ-030 mask sampled only in IDLE/GAP exit and SELECT; changes mid-transaction SHALL NOT affect the current slave.
REQ-031 Timeout and ss rising in same cycle: capture SHALL win, no timeout_err.
REQ-032 Round-robin pointer SHALL advance on timeout as on capture.

Reset
REQ-033 On reset: state IDLE, sendOrder=0, ssi=00, address=8'h00, result1..3=8'h00, valid=000, upd=0, upd_idx=00, timeout_err=0, counters 0, last-served = slave 3.
REQ-034 Reset asserted mid-transaction SHALL return to IDLE immediately, no capture or pulse.

Verification
REQ-035 mask=001, enable=1, master model returns 8'h4c on slave 1 -> sendOrder 2 cycles, ssi=01, address=03, result1=4c, valid=001, upd_idx=01.
REQ-036 mask=111, slaves return 4c/88/77 -> captures in order 1,2,3,1, GAP of POLL_GAP cycles between sendOrder pulses.
REQ-037 mask=101 -> ssi sequence 01,11,01; slave 2 never addressed, valid[1]=0.
REQ-038 Slave 2 never asserts ss2, mask=010 -> timeout_err at TIMEOUT cycles after ISSUE entry, result2=00, valid=000, retry after GAP.
REQ-039 enable dropped during WAIT_END -> capture occurs, then IDLE, sendOrder stays 0.
REQ-040 reset pulsed during WAIT_END -> all outputs to REQ-033 values same cycle, no upd.
